video_timing_gen: RTL

- Generates 640x480@60 raster timing in the pixel clock domain and issues pixel-coordinate requests to a pixel source (framebuffer or sprite logic).
- Delays hsync/vsync/blank to match the pixel source latency, then registers them together with the returned 3-bit colours.
- Sits directly upstream of the DVI/TMDS encoder: its hsync, vsync, blank, red, green and blue outputs drive the encoder inputs.

---
 rtl/video_timing_pkg.sv | 27 ++
 rtl/video_timing_if.sv | 32 +++
 rtl/pipe_delay.sv | 35 +++
 rtl/video_timing_gen.sv | 95 +++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared 640x480@60 raster constants and payload types for the video path.
package video_timing_pkg;

    localparam int unsigned CW       = 10;
    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic SYNC_POL_DEFAULT = 1'b1;

    // Timing controls carried alongside the pixel pipeline.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic blank;
    } sync_t;

    localparam int unsigned SYNC_W = $bits(sync_t);

endpackage

// File: rtl/video_timing_if.sv
// Pixel-request / colour-return bus plus the encoder-facing outputs.
interface video_timing_if;
    import video_timing_pkg::*;

    logic [CW-1:0] pix_x;
    logic [CW-1:0] pix_y;
    logic          pix_valid;
    logic          line_start;
    logic          frame_start;
    logic [2:0]    red_in;
    logic [2:0]    green_in;
    logic [2:0]    blue_in;
    logic          hsync;
    logic          vsync;
    logic          blank;
    logic [2:0]    red;
    logic [2:0]    green;
    logic [2:0]    blue;

    modport master (
        output pix_x, pix_y, pix_valid, line_start, frame_start,
        output hsync, vsync, blank, red, green, blue,
        input  red_in, green_in, blue_in
    );

    modport slave (
        input  pix_x, pix_y, pix_valid, line_start, frame_start,
        input  hsync, vsync, blank, red, green, blue,
        output red_in, green_in, blue_in
    );

endinterface

// File: rtl/pipe_delay.sv
// WIDTH x DEPTH shift register with asynchronous reset; DEPTH = 0 is a wire.
module pipe_delay #(
    parameter int unsigned      WIDTH       = 1,
    parameter int unsigned      DEPTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign dout = din;
        end else begin : g_shift
            logic [WIDTH-1:0] stage [DEPTH];

            // Shift one stage per clock; every stage resets to the idle value.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < int'(DEPTH); i++) stage[i] <= RESET_VALUE;
                end else begin
                    stage[0] <= din;
                    for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel requests out, delay-matched sync/blank/colour
// to the TMDS encoder.
module video_timing_gen
    import video_timing_pkg::CW, video_timing_pkg::sync_t, video_timing_pkg::SYNC_W;
#(
    parameter int unsigned H_ACTIVE = video_timing_pkg::H_ACTIVE,
    parameter int unsigned H_FP     = video_timing_pkg::H_FP,
    parameter int unsigned H_SYNC   = video_timing_pkg::H_SYNC,
    parameter int unsigned H_BP     = video_timing_pkg::H_BP,
    parameter int unsigned V_ACTIVE = video_timing_pkg::V_ACTIVE,
    parameter int unsigned V_FP     = video_timing_pkg::V_FP,
    parameter int unsigned V_SYNC   = video_timing_pkg::V_SYNC,
    parameter int unsigned V_BP     = video_timing_pkg::V_BP,
    parameter logic        SYNC_POL = video_timing_pkg::SYNC_POL_DEFAULT,
    parameter int unsigned PIPE_LAT = 2
) (
    input  logic          clk,
    input  logic          reset,
    video_timing_if.master bus
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    localparam sync_t SYNC_IDLE = '{hsync: ~SYNC_POL, vsync: ~SYNC_POL, blank: 1'b1};

    logic [CW-1:0] h;
    logic [CW-1:0] v;
    logic          active_c;
    sync_t         raw_c;
    sync_t         del_c;

    // Raster counters: h every clock, v on each h wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h <= '0;
            v <= '0;
        end else if (h == CW'(H_TOTAL - 1)) begin
            h <= '0;
            v <= (v == CW'(V_TOTAL - 1)) ? '0 : v + CW'(1);
        end else begin
            h <= h + CW'(1);
        end
    end

    // Stage-0 request and raw timing, decoded straight from the counters.
    always_comb begin
        active_c     = (h < CW'(H_ACTIVE)) && (v < CW'(V_ACTIVE));
        raw_c.hsync  = ((h >= CW'(HS_START)) && (h < CW'(HS_END))) ? SYNC_POL : ~SYNC_POL;
        raw_c.vsync  = ((v >= CW'(VS_START)) && (v < CW'(VS_END))) ? SYNC_POL : ~SYNC_POL;
        raw_c.blank  = ~active_c;
    end

    assign bus.pix_x       = h;
    assign bus.pix_y       = v;
    assign bus.pix_valid   = active_c;
    assign bus.line_start  = (h == '0);
    assign bus.frame_start = (h == '0) && (v == '0);

    // Align sync/blank with the pixel source's colour latency.
    pipe_delay #(
        .WIDTH       (SYNC_W),
        .DEPTH       (PIPE_LAT),
        .RESET_VALUE (SYNC_IDLE)
    ) u_sync_delay (
        .clk  (clk),
        .rst  (reset),
        .din  (raw_c),
        .dout (del_c)
    );

    // Output register: delayed timing plus colour, colour forced black in blanking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.hsync <= ~SYNC_POL;
            bus.vsync <= ~SYNC_POL;
            bus.blank <= 1'b1;
            bus.red   <= '0;
            bus.green <= '0;
            bus.blue  <= '0;
        end else begin
            bus.hsync <= del_c.hsync;
            bus.vsync <= del_c.vsync;
            bus.blank <= del_c.blank;
            bus.red   <= del_c.blank ? 3'd0 : bus.red_in;
            bus.green <= del_c.blank ? 3'd0 : bus.green_in;
            bus.blue  <= del_c.blank ? 3'd0 : bus.blue_in;
        end
    end

endmodule
